// File: rtl/video_dnn_argmax.sv
// Pipelined per-pixel argmax over the DNN class-count stream with threshold detect.
// Optional per-class frame histogram: define VIDEO_DNN_ARGMAX_HIST_EN.
module video_dnn_argmax #(
    parameter int NUM_CLASS      = 10,
    parameter int COUNT_WIDTH    = 3,
    parameter int CLASS_WIDTH    = 4,
    parameter int TUSER_WIDTH    = 1,
    parameter int THRESHOLD_INIT = 1,
    parameter int HIST_WIDTH     = 20
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             aclken,
    input  logic [COUNT_WIDTH-1:0]           param_threshold,
    input  logic [TUSER_WIDTH-1:0]           s_axi4s_tuser,
    input  logic                             s_axi4s_tlast,
    input  logic [NUM_CLASS*COUNT_WIDTH-1:0] s_axi4s_tcount,
    input  logic                             s_axi4s_tvalid,
    output logic                             s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]           m_axi4s_tuser,
    output logic                             m_axi4s_tlast,
    output logic [CLASS_WIDTH-1:0]           m_axi4s_tclass,
    output logic [COUNT_WIDTH-1:0]           m_axi4s_tcount,
    output logic                             m_axi4s_tdetect,
    output logic                             m_axi4s_tvalid,
    input  logic                             m_axi4s_tready,
    output logic [NUM_CLASS*HIST_WIDTH-1:0]  m_hist,
    output logic                             m_hist_valid
);

    // One tree level per stage; the last stage also registers the detect decision.
    localparam int LEVELS = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;

    typedef logic [CLASS_WIDTH-1:0] idx_t;
    typedef logic [COUNT_WIDTH-1:0] cnt_t;

    function automatic int width_at(input int lvl);
        int n;
        n = NUM_CLASS;
        for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
        return n;
    endfunction

    logic                   cke;
    cnt_t                   thr_shadow;
    cnt_t                   eff_thr;
    logic                   det_q;
    logic                   n_det;

    logic                   vld_q  [LEVELS];
    logic [TUSER_WIDTH-1:0] user_q [LEVELS];
    logic                   last_q [LEVELS];
    cnt_t                   thr_q  [LEVELS];
    idx_t                   idx_q  [LEVELS][NUM_CLASS];
    cnt_t                   cnt_q  [LEVELS][NUM_CLASS];

    logic                   p_vld  [LEVELS];
    logic [TUSER_WIDTH-1:0] p_user [LEVELS];
    logic                   p_last [LEVELS];
    cnt_t                   p_thr  [LEVELS];
    idx_t                   p_idx  [LEVELS][NUM_CLASS];
    cnt_t                   p_cnt  [LEVELS][NUM_CLASS];
    idx_t                   n_idx  [LEVELS][NUM_CLASS];
    cnt_t                   n_cnt  [LEVELS][NUM_CLASS];

    assign cke            = aclken & (~vld_q[LEVELS-1] | m_axi4s_tready);
    assign s_axi4s_tready = cke;

    // A frame-start beat already uses the threshold it carries.
    assign eff_thr = s_axi4s_tuser[0] ? param_threshold : thr_shadow;

    always_comb begin
        p_vld[0]  = s_axi4s_tvalid;
        p_user[0] = s_axi4s_tuser;
        p_last[0] = s_axi4s_tlast;
        p_thr[0]  = eff_thr;
        for (int j = 0; j < NUM_CLASS; j++) begin
            p_idx[0][j] = idx_t'(j);
            p_cnt[0][j] = s_axi4s_tcount[j*COUNT_WIDTH +: COUNT_WIDTH];
        end
        for (int s = 1; s < LEVELS; s++) begin
            p_vld[s]  = vld_q[s-1];
            p_user[s] = user_q[s-1];
            p_last[s] = last_q[s-1];
            p_thr[s]  = thr_q[s-1];
            for (int j = 0; j < NUM_CLASS; j++) begin
                p_idx[s][j] = idx_q[s-1][j];
                p_cnt[s][j] = cnt_q[s-1][j];
            end
        end
    end

    // Lower index sits in the even slot, so only a strictly larger odd slot wins.
    always_comb begin
        for (int s = 0; s < LEVELS; s++) begin
            for (int j = 0; j < NUM_CLASS; j++) begin
                n_idx[s][j] = '0;
                n_cnt[s][j] = '0;
            end
        end
        for (int s = 0; s < LEVELS; s++) begin
            for (int j = 0; j < (NUM_CLASS + 1) / 2; j++) begin
                int a;
                int b;
                a = 2 * j;
                b = (2 * j + 1 < NUM_CLASS) ? 2 * j + 1 : 2 * j;
                if (j < width_at(s + 1)) begin
                    if (2 * j + 1 < width_at(s) && p_cnt[s][b] > p_cnt[s][a]) begin
                        n_idx[s][j] = p_idx[s][b];
                        n_cnt[s][j] = p_cnt[s][b];
                    end else begin
                        n_idx[s][j] = p_idx[s][a];
                        n_cnt[s][j] = p_cnt[s][a];
                    end
                end
            end
        end
        n_det = n_cnt[LEVELS-1][0] >= p_thr[LEVELS-1];
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int s = 0; s < LEVELS; s++) vld_q[s] <= 1'b0;
            det_q      <= 1'b0;
            thr_shadow <= cnt_t'(THRESHOLD_INIT);
        end else if (cke) begin
            for (int s = 0; s < LEVELS; s++) begin
                vld_q[s]  <= p_vld[s];
                user_q[s] <= p_user[s];
                last_q[s] <= p_last[s];
                thr_q[s]  <= p_thr[s];
                for (int j = 0; j < NUM_CLASS; j++) begin
                    idx_q[s][j] <= n_idx[s][j];
                    cnt_q[s][j] <= n_cnt[s][j];
                end
            end
            det_q <= n_det;
            if (s_axi4s_tvalid && s_axi4s_tuser[0]) thr_shadow <= param_threshold;
        end
    end

    assign m_axi4s_tvalid  = vld_q[LEVELS-1];
    assign m_axi4s_tuser   = user_q[LEVELS-1];
    assign m_axi4s_tlast   = last_q[LEVELS-1];
    assign m_axi4s_tcount  = cnt_q[LEVELS-1][0];
    assign m_axi4s_tdetect = det_q;
    assign m_axi4s_tclass  = det_q ? idx_q[LEVELS-1][0] : idx_t'(NUM_CLASS);

`ifdef VIDEO_DNN_ARGMAX_HIST_EN
    typedef logic [HIST_WIDTH-1:0] hist_t;

    hist_t                          hcnt [NUM_CLASS];
    logic [NUM_CLASS*HIST_WIDTH-1:0] hist_q;
    logic                           hist_vld_q;
    logic                           out_hs;
    logic [NUM_CLASS-1:0]           hit;

    assign out_hs = m_axi4s_tvalid & m_axi4s_tready;

    always_comb begin
        for (int i = 0; i < NUM_CLASS; i++)
            hit[i] = det_q && (idx_q[LEVELS-1][0] == idx_t'(i));
    end

    // Frame start snapshots the previous frame, then counting restarts with this beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_CLASS; i++) hcnt[i] <= '0;
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
        end else if (aclken) begin
            hist_vld_q <= out_hs & m_axi4s_tuser[0];
            if (out_hs) begin
                for (int i = 0; i < NUM_CLASS; i++) begin
                    if (m_axi4s_tuser[0]) begin
                        hist_q[i*HIST_WIDTH +: HIST_WIDTH] <= hcnt[i];
                        hcnt[i] <= hit[i] ? hist_t'(1) : '0;
                    end else if (hit[i] && hcnt[i] != '1) begin
                        hcnt[i] <= hcnt[i] + hist_t'(1);
                    end
                end
            end
        end
    end

    assign m_hist       = hist_q;
    assign m_hist_valid = hist_vld_q;
`else
    assign m_hist       = '0;
    assign m_hist_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_dnn_argmax.sv
// Bench for video_dnn_argmax: transaction model plus directed literal checks.
// Histogram checks are active when VIDEO_DNN_ARGMAX_HIST_EN is defined.
module tb_video_dnn_argmax;

    logic         aclk;
    logic         aresetn;
    logic         aclken;
    logic [2:0]   param_threshold;
    logic [0:0]   s_tuser;
    logic         s_tlast;
    logic [29:0]  s_tcount;
    logic         s_tvalid;
    logic         s_tready;
    logic [0:0]   m_tuser;
    logic         m_tlast;
    logic [3:0]   m_tclass;
    logic [2:0]   m_tcount;
    logic         m_tdetect;
    logic         m_tvalid;
    logic         m_tready;
    logic [199:0] m_hist;
    logic         m_hist_valid;

    video_dnn_argmax dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .aclken          (aclken),
        .param_threshold (param_threshold),
        .s_axi4s_tuser   (s_tuser),
        .s_axi4s_tlast   (s_tlast),
        .s_axi4s_tcount  (s_tcount),
        .s_axi4s_tvalid  (s_tvalid),
        .s_axi4s_tready  (s_tready),
        .m_axi4s_tuser   (m_tuser),
        .m_axi4s_tlast   (m_tlast),
        .m_axi4s_tclass  (m_tclass),
        .m_axi4s_tcount  (m_tcount),
        .m_axi4s_tdetect (m_tdetect),
        .m_axi4s_tvalid  (m_tvalid),
        .m_axi4s_tready  (m_tready),
        .m_hist          (m_hist),
        .m_hist_valid    (m_hist_valid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [3:0] cls;
        logic [2:0] cnt;
        logic       det;
        logic       usr;
        logic       lst;
    } beat_t;

    int     checks = 0;
    int     passed = 0;
    beat_t  q[$];
    int     m_thr = 1;
    logic   stall_v = 1'b0;
    beat_t  stall_s;
    logic   rst_seen = 1'b0;
    logic   rnd_mode = 1'b0;
    int     hist_pulses = 0;
    logic [199:0] hist_first = '0;
    logic [199:0] hist_last = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) $display("FAIL %s got=%0h want=%0h", nm, got, want);
        else passed++;
    endtask

    function automatic logic [29:0] pack(input int c[10]);
        logic [29:0] r;
        for (int i = 0; i < 10; i++) r[i*3 +: 3] = 3'(c[i]);
        return r;
    endfunction

    // Plain argmax scan: first index holding the largest count.
    function automatic beat_t model(input logic [29:0] tc, input int thr,
                                    input logic u, input logic l);
        beat_t e;
        int best;
        int bi;
        best = int'(tc[2:0]);
        bi = 0;
        for (int i = 1; i < 10; i++) begin
            if (int'(tc[i*3 +: 3]) > best) begin
                best = int'(tc[i*3 +: 3]);
                bi = i;
            end
        end
        e.cnt = 3'(best);
        e.det = (best >= thr);
        e.cls = e.det ? 4'(bi) : 4'd10;
        e.usr = u;
        e.lst = l;
        return e;
    endfunction

    always @(negedge aclk) begin
        beat_t cur;
        cur.cls = m_tclass;
        cur.cnt = m_tcount;
        cur.det = m_tdetect;
        cur.usr = m_tuser[0];
        cur.lst = m_tlast;
        if (!aresetn) begin
            q.delete();
            m_thr = 1;
            stall_v = 1'b0;
            rst_seen = 1'b1;
            hist_pulses = 0;
        end else begin
            if (rst_seen) chk("post_reset_tvalid", 64'(m_tvalid), 64'd0);
            rst_seen = 1'b0;
            if (stall_v) chk("stall_hold", {m_tvalid, cur}, {1'b1, stall_s});
            stall_v = m_tvalid && !(m_tready && aclken);
            stall_s = cur;
            if (m_tvalid && m_tready && aclken) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL extra_beat got=%0h want=none", cur);
                end else begin
                    beat_t e;
                    passed++;
                    e = q.pop_front();
                    chk("beat", cur, e);
                end
            end
            if (s_tvalid && s_tready) begin
                if (s_tuser[0]) m_thr = int'(param_threshold);
                q.push_back(model(s_tcount, m_thr, s_tuser[0], s_tlast));
            end
            if (m_hist_valid) begin
                if (hist_pulses == 0) hist_first = m_hist;
                hist_last = m_hist;
                hist_pulses++;
            end
        end
    end

    always @(posedge aclk) begin
        #1;
        if (rnd_mode) begin
            m_tready = 1'($urandom_range(0, 1));
            aclken = ($urandom_range(0, 9) != 0);
        end
    end

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic send(input logic [29:0] tc, input logic u, input logic l);
        int n;
        n = 0;
        s_tcount = tc;
        s_tuser = u;
        s_tlast = l;
        s_tvalid = 1'b1;
        while (!s_tready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("send_timeout", 64'(n), 64'd0);
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!(m_tvalid && m_tready && aclken) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("wait_out_timeout", 64'(n), 64'd0);
    endtask

    task automatic expect_out(input string nm, input int cls, input int cnt, input int det);
        int n;
        wait_out(n);
        chk({nm, "_class"}, 64'(m_tclass), 64'(cls));
        chk({nm, "_count"}, 64'(m_tcount), 64'(cnt));
        chk({nm, "_detect"}, 64'(m_tdetect), 64'(det));
    endtask

    initial begin
        int n;
        logic [29:0] tc;
        logic [29:0] c5;
        logic [29:0] zero;
        logic [29:0] c1;
        aresetn = 1'b0;
        aclken = 1'b1;
        param_threshold = 3'd1;
        s_tuser = 1'b0;
        s_tlast = 1'b0;
        s_tcount = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (3) tick();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("ready_after_reset", 64'(s_tready), 64'd1);
        chk("hist_valid_reset", 64'(m_hist_valid), 64'd0);
        tick();

        send(pack('{1, 3, 7, 2, 0, 0, 0, 0, 0, 5}), 1'b1, 1'b0);
        wait_out(n);
        chk("latency", 64'(n + 1), 64'd4);
        chk("basic_class", 64'(m_tclass), 64'd2);
        chk("basic_count", 64'(m_tcount), 64'd7);
        chk("basic_detect", 64'(m_tdetect), 64'd1);

        send(pack('{0, 0, 0, 4, 0, 0, 4, 0, 0, 0}), 1'b0, 1'b0);
        expect_out("tie", 3, 4, 1);
        zero = '0;
        send(zero, 1'b0, 1'b1);
        expect_out("zero", 10, 0, 0);
        send(pack('{5, 5, 5, 5, 5, 5, 5, 5, 5, 5}), 1'b0, 1'b0);
        expect_out("equal", 0, 5, 1);
        send(pack('{0, 0, 0, 0, 0, 0, 0, 0, 0, 7}), 1'b0, 1'b0);
        expect_out("last_odd", 9, 7, 1);

        c5 = pack('{0, 0, 0, 0, 0, 4, 0, 0, 0, 0});
        param_threshold = 3'd6;
        send(c5, 1'b1, 1'b0);
        expect_out("thr6", 10, 4, 0);
        param_threshold = 3'd2;
        send(c5, 1'b0, 1'b0);
        expect_out("thr_held", 10, 4, 0);
        send(c5, 1'b1, 1'b0);
        expect_out("thr2", 5, 4, 1);
        param_threshold = 3'd0;
        send(zero, 1'b1, 1'b0);
        expect_out("thr0", 0, 0, 1);
        param_threshold = 3'd1;
        send(zero, 1'b1, 1'b0);
        expect_out("thr1_zero", 10, 0, 0);

        rnd_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 1) == 0) tick();
            param_threshold = 3'($urandom_range(0, 7));
            tc = 30'($urandom);
            send(tc, (i % 25) == 0, (i % 5) == 4);
        end
        rnd_mode = 1'b0;
        tick();
        m_tready = 1'b1;
        aclken = 1'b1;
        repeat (20) tick();
        chk("random_drained", 64'(q.size()), 64'd0);

        param_threshold = 3'd1;
        send(pack('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0}), 1'b1, 1'b0);
        send(pack('{0, 2, 0, 0, 0, 0, 0, 0, 0, 0}), 1'b0, 1'b0);
        send(pack('{0, 0, 3, 0, 0, 0, 0, 0, 0, 0}), 1'b0, 1'b0);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        repeat (12) tick();
        chk("reset_flushed", 64'(q.size()), 64'd0);

        c1 = pack('{0, 5, 0, 0, 0, 0, 0, 0, 0, 0});
        for (int p = 0; p < 16; p++) send(c1, p == 0, (p % 4) == 3);
        send(c1, 1'b1, 1'b0);
        repeat (10) tick();
`ifdef VIDEO_DNN_ARGMAX_HIST_EN
        chk("hist_pulses", 64'(hist_pulses), 64'd2);
        chk("hist_first_zero", 64'(|hist_first), 64'd0);
        chk("hist_class1", 64'(hist_last[20 +: 20]), 64'd16);
        chk("hist_class0", 64'(hist_last[0 +: 20]), 64'd0);
        chk("hist_upper", 64'(|hist_last[199:40]), 64'd0);
`else
        chk("hist_pulses_off", 64'(hist_pulses), 64'd0);
        chk("hist_tied", 64'(|m_hist), 64'd0);
`endif
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule
